// File: rtl/stream2native_skid_pkg.sv
// ============================================================================
// stream2native_skid_pkg : shared widths, field offsets and buffer states
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package stream2native_skid_pkg;

   localparam int C_BYTE_W = 8;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   function automatic int keep_w(input int width);
      return width / C_BYTE_W;
   endfunction

   // FIFO word is {tlast, [tkeep,] tdata}
   function automatic int fifo_w(input int width, input int store_keep);
      return width + 1 + ((store_keep != 0) ? keep_w(width) : 0);
   endfunction

   function automatic int last_bit(input int width, input int store_keep);
      return fifo_w(width, store_keep) - 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stream2native_skid_skid_buf2.sv
// ============================================================================
// stream2native_skid_skid_buf2 : 2-entry FIFO with registered ready
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module stream2native_skid_skid_buf2
   import stream2native_skid_pkg::*;
#(
   parameter int DW = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          stall,
   output logic [DW-1:0] dout,
   output logic          pop,
   output logic          ready
);

   occ_e          r_state;
   occ_e          w_state_nxt;
   logic [DW-1:0] r_head;
   logic [DW-1:0] r_tail;
   logic [DW-1:0] w_head_nxt;
   logic [DW-1:0] w_tail_nxt;
   logic          r_ready;
   logic          w_push;
   logic          w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= OCC_EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_ready <= (w_state_nxt != OCC_TWO);
      end
   end

   // Ready is low exactly while two entries are held, so no push can occur in OCC_TWO.
   always_comb begin
      w_push      = push & r_ready;
      w_pop       = (r_state != OCC_EMPTY) & ~stall & ~rst;
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      case (r_state)
         OCC_EMPTY: begin
            if (w_push) begin
               w_head_nxt  = din;
               w_state_nxt = OCC_ONE;
            end
         end
         OCC_ONE: begin
            case ({w_push, w_pop})
               2'b10: begin
                  w_tail_nxt  = din;
                  w_state_nxt = OCC_TWO;
               end
               2'b01: w_state_nxt = OCC_EMPTY;
               2'b11: w_head_nxt  = din;
               default: ;
            endcase
         end
         OCC_TWO: begin
            if (w_pop) begin
               w_head_nxt  = r_tail;
               w_state_nxt = OCC_ONE;
            end
         end
         default: w_state_nxt = OCC_EMPTY;
      endcase
   end

   assign dout  = r_head;
   assign pop   = w_pop;
   assign ready = r_ready;

endmodule

`default_nettype wire

// File: rtl/stream2native_skid.sv
// ============================================================================
// stream2native_skid : AXI-Stream slave to native FIFO write adapter
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module stream2native_skid
   import stream2native_skid_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int STORE_KEEP     = 0,
   parameter int KEEP_NULL_LAST = 1,
   parameter int CNT_W          = 32,
   localparam int KW            = keep_w(WIDTH),
   localparam int FW            = fifo_w(WIDTH, STORE_KEEP)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_full,
   output logic [FW-1:0]    fifo_data,
   output logic             fifo_wr,
   output logic             s_axis_tready,
   input  logic             s_axis_tvalid,
   input  logic [WIDTH-1:0] s_axis_tdata,
   input  logic [KW-1:0]    s_axis_tkeep,
   input  logic             s_axis_tlast,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] beat_count,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] null_count
);

   localparam int   C_LAST_BIT  = last_bit(WIDTH, STORE_KEEP);
   localparam logic C_NULL_LAST = (KEEP_NULL_LAST != 0);

   logic             w_accept;
   logic             w_qualify;
   logic             w_push;
   logic             w_null;
   logic [FW-1:0]    w_word;
   logic [CNT_W-1:0] r_beat;
   logic [CNT_W-1:0] r_frame;
   logic [CNT_W-1:0] r_null;

   assign w_accept  = s_axis_tvalid & s_axis_tready;
   assign w_qualify = (|s_axis_tkeep) | (s_axis_tlast & C_NULL_LAST);
   assign w_push    = w_accept & w_qualify;
   assign w_null    = w_accept & ~w_qualify;

   generate
      if (STORE_KEEP != 0) begin : g_keep
         assign w_word = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
      end else begin : g_nokeep
         assign w_word = {s_axis_tlast, s_axis_tdata};
      end
   endgenerate

   stream2native_skid_skid_buf2 #(
      .DW (FW)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .din   (w_word),
      .stall (fifo_full),
      .dout  (fifo_data),
      .pop   (fifo_wr),
      .ready (s_axis_tready)
   );

   // Clear beats any increment landing in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_beat  <= '0;
         r_frame <= '0;
         r_null  <= '0;
      end else begin
         if (fifo_wr)                         r_beat  <= r_beat + CNT_W'(1);
         if (fifo_wr && fifo_data[C_LAST_BIT]) r_frame <= r_frame + CNT_W'(1);
         if (w_null)                          r_null  <= r_null + CNT_W'(1);
      end
   end

   assign beat_count  = r_beat;
   assign frame_count = r_frame;
   assign null_count  = r_null;

endmodule

`default_nettype wire
